// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of the requester handshakes and the memory-macro bus around
// mem_port_arbiter.
//   slave  : arbiter side. It takes requests and read data in, and drives the
//            acks, the rdata registers and the memory strobes out.
//   master : environment side, meaning the two requesters plus the memory.
// Signals:
//   rX_req/we/addr/wdata  request and payload from requester X (0 = CPU, 1 = loader)
//   rX_lock               grant retention request (only when ARB_LOCK_EN is defined)
//   rX_ack/rX_rdata       completion pulse and registered read data to requester X
//   mem_en/we/addr/wdata  memory access strobe and payload
//   mem_rdata             memory read data, valid one cycle after mem_en
//   busy, grant_id        arbiter status
// Optional feature macro: ARB_LOCK_EN
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              r0_req;
  logic              r1_req;
  logic              r0_we;
  logic              r1_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r1_wdata;
  logic              r0_ack;
  logic              r1_ack;
  logic [DATA_W-1:0] r0_rdata;
  logic [DATA_W-1:0] r1_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              grant_id;
`ifdef ARB_LOCK_EN
  logic              r0_lock;
  logic              r1_lock;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  r0_lock, r1_lock, mem_rdata,
    output r0_ack, r1_ack, r0_rdata, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output r0_lock, r1_lock, mem_rdata,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );
`else
  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  mem_rdata,
    output r0_ack, r1_ack, r0_rdata, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output mem_rdata,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant_id
  );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the CPU memory port
// (requester 0) and the program-loader/debug port (requester 1). Each
// transaction runs through IDLE -> ISSUE -> RESP. The arbiter grants
// round-robin on contention and completes with a one-cycle ack in RESP.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-high reset. It aborts any transaction in flight
//          without an ack and clears the read-data registers.
//   bus    mem_port_arbiter_if.slave (requester handshakes and memory bus)
// Optional feature macro: ARB_LOCK_EN. When it is defined, a locking owner that
// still requests in the next IDLE is re-granted, up to LOCK_MAX times in a row.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
`ifdef ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 8
`endif
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel_s;
  logic              lock_hit_s;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r1_ack_q, r1_ack_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

`ifdef ARB_LOCK_EN
  // The counter is 4 bits wide, so LOCK_MAX is expected to stay below 16.
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic       lock_pend_q, lock_pend_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       grant_s;
  logic       owner_req_s;

  assign grant_s     = (state_q == IDLE) && (bus.r0_req || bus.r1_req);
  assign owner_req_s = owner_q ? bus.r1_req : bus.r0_req;
  // A lock taken in RESP holds only for the IDLE cycle that immediately
  // follows, and only while the consecutive-lock budget is not used up.
  assign lock_hit_s  = lock_pend_q && owner_req_s && (lock_cnt_q < LOCK_MAX_C);

  // Lock bookkeeping: sample the owner's lock in RESP, count locked re-grants
  always_comb begin
    lock_pend_d = lock_pend_q;
    lock_cnt_d  = lock_cnt_q;
    if (state_q == RESP) begin
      lock_pend_d = owner_q ? bus.r1_lock : bus.r0_lock;
    end else if (state_q == IDLE) begin
      lock_pend_d = 1'b0;
      if (grant_s) begin
        if (lock_hit_s) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
          lock_cnt_d = 4'd0;
        end
      end else begin
        lock_cnt_d = lock_cnt_q;
      end
    end else begin
      lock_pend_d = lock_pend_q;
    end
  end

  // Lock state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_pend_q <= 1'b0;
      lock_cnt_q  <= 4'd0;
    end else begin
      lock_pend_q <= lock_pend_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end
`else
  assign lock_hit_s = 1'b0;
`endif

  // FSM state register with the latched owner and payload
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then step through ISSUE and RESP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          if (lock_hit_s) begin
            sel_s = owner_q;
          end else if (bus.r0_req && bus.r1_req) begin
            sel_s = ~last_q;
          end else begin
            sel_s = bus.r1_req;
          end
          state_d = ISSUE;
          owner_d = sel_s;
          last_d  = sel_s;
          // Latch the payload here so requester changes in flight are ignored.
          if (sel_s) begin
            we_d    = bus.r1_we;
            addr_d  = bus.r1_addr;
            wdata_d = bus.r1_wdata;
          end else begin
            we_d    = bus.r0_we;
            addr_d  = bus.r0_addr;
            wdata_d = bus.r0_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. It is based on the next state, so that the registered
  // outputs line up with the state they belong to.
  always_comb begin
    mem_en_d   = (state_d == ISSUE);
    mem_we_d   = (state_d == ISSUE) && we_d;
    busy_d     = (state_d != IDLE);
    r0_ack_d   = (state_d == RESP) && !owner_d;
    r1_ack_d   = (state_d == RESP) && owner_d;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    // mem_rdata is valid during RESP and is captured into the owner's register only.
    if ((state_q == RESP) && !we_q) begin
      if (owner_q) begin
        r1_rdata_d = bus.mem_rdata;
      end else begin
        r0_rdata_d = bus.mem_rdata;
      end
    end else begin
      r0_rdata_d = r0_rdata_q;
      r1_rdata_d = r1_rdata_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = owner_q;
  assign bus.r0_ack    = r0_ack_q;
  assign bus.r1_ack    = r1_ack_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter. Each requester has a command queue.
// The expected completions are pushed in their predicted grant order, and each
// ack pops one entry and compares it. Read data is compared on the cycle after
// the ack, once the rdata register has updated. A behavioural memory answers
// mem_en one cycle later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        lock;
  } cmd_t;

  typedef struct packed {
    logic        port;
    logic        is_read;
    logic [15:0] data;
    logic [3:0]  gap;   // expected cycles since the previous ack; 0 = not checked
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

  mem_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];

  // Behavioural single-port memory: read data one cycle after mem_en
  always @(posedge clock) begin
    if (bus_if.mem_en) begin
      if (bus_if.mem_we) begin
        mem_arr[bus_if.mem_addr] <= bus_if.mem_wdata;
      end
      bus_if.mem_rdata <= mem_arr[bus_if.mem_addr];
    end
  end

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  int          tcyc = 0;
  int          last_ack_cyc = 0;
  cmd_t        q0[$];
  cmd_t        q1[$];
  exp_t        exp_q[$];
  logic        rd_pend = 1'b0;
  logic        rd_port = 1'b0;
  logic [15:0] rd_exp = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [3:0] gap);
    exp_t e;
    e.port    = port;
    e.is_read = !we;
    e.data    = we ? 16'h0000 : ref_mem[addr];
    e.gap     = gap;
    if (we) begin
      ref_mem[addr] = wdata;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_ports();
    cmd_t c;
    if (q0.size() > 0) begin
      c = q0[0];
      bus_if.r0_req   = 1'b1;
      bus_if.r0_we    = c.we;
      bus_if.r0_addr  = c.addr;
      bus_if.r0_wdata = c.wdata;
`ifdef ARB_LOCK_EN
      bus_if.r0_lock  = c.lock;
`endif
    end else begin
      bus_if.r0_req = 1'b0;
    end
    if (q1.size() > 0) begin
      c = q1[0];
      bus_if.r1_req   = 1'b1;
      bus_if.r1_we    = c.we;
      bus_if.r1_addr  = c.addr;
      bus_if.r1_wdata = c.wdata;
`ifdef ARB_LOCK_EN
      bus_if.r1_lock  = c.lock;
`endif
    end else begin
      bus_if.r1_req = 1'b0;
    end
  endtask

  // One cycle: observe at the falling edge, score any ack, then drive the requesters.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    tcyc++;
    if (rd_pend) begin
      if (rd_port) chk("r1_rdata", 32'(bus_if.r1_rdata), 32'(rd_exp));
      else         chk("r0_rdata", 32'(bus_if.r0_rdata), 32'(rd_exp));
      rd_pend = 1'b0;
    end
    if (bus_if.r0_ack || bus_if.r1_ack) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", {30'd0, bus_if.r1_ack, bus_if.r0_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {30'd0, bus_if.r1_ack, bus_if.r0_ack}, e.port ? 32'd2 : 32'd1);
        chk("grant_id", 32'(bus_if.grant_id), 32'(e.port));
        if (e.gap != 4'd0) chk("ack_gap", 32'(tcyc - last_ack_cyc), 32'(e.gap));
        if (e.is_read) begin
          rd_pend = 1'b1;
          rd_port = e.port;
          rd_exp  = e.data;
        end
      end
      last_ack_cyc = tcyc;
      if (bus_if.r0_ack && q0.size() > 0) void'(q0.pop_front());
      if (bus_if.r1_ack && q1.size() > 0) void'(q1.pop_front());
    end
    drive_ports();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rd_pend) && n < budget) begin
      tick();
      n++;
    end
    chk("timeout_pending", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic cmd_t mk(input logic we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic lock);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.lock = lock;
    return c;
  endfunction

  initial begin
    bus_if.r0_req = 1'b0; bus_if.r1_req = 1'b0;
    bus_if.r0_we = 1'b0; bus_if.r1_we = 1'b0;
    bus_if.r0_addr = 16'h0000; bus_if.r1_addr = 16'h0000;
    bus_if.r0_wdata = 16'h0000; bus_if.r1_wdata = 16'h0000;
`ifdef ARB_LOCK_EN
    bus_if.r0_lock = 1'b0; bus_if.r1_lock = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    mem_arr[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    // Reset, then idle for 10 cycles with both requests low
    tick(); tick();
    reset = 1'b0;
    chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
    chk("rst_rdata", {bus_if.r1_rdata, bus_if.r0_rdata}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {26'd0, bus_if.mem_en, bus_if.mem_we, bus_if.busy,
                        bus_if.grant_id, bus_if.r0_ack, bus_if.r1_ack}, 32'd0);
    end

    // Single read from requester 0, with latency checks
    q0.push_back(mk(1'b0, 16'h0010, 16'h0000, 1'b0));
    push_exp(1'b0, 1'b0, 16'h0010, 16'h0000, 4'd0);
    tick();
    tick();
    chk("rd_mem_en_n1", {30'd0, bus_if.mem_en, bus_if.mem_we}, 32'd2);
    chk("rd_mem_addr", 32'(bus_if.mem_addr), 32'h0010);
    chk("rd_busy_issue", 32'(bus_if.busy), 32'd1);
    tick();
    chk("rd_ack_n2", {30'd0, bus_if.r0_ack, bus_if.mem_en}, 32'd2);
    run_until_done(20);

    // Write then read back-to-back on requester 1
    q1.push_back(mk(1'b1, 16'h0020, 16'h1234, 1'b0));
    q1.push_back(mk(1'b0, 16'h0020, 16'h0000, 1'b0));
    push_exp(1'b1, 1'b1, 16'h0020, 16'h1234, 4'd0);
    push_exp(1'b1, 1'b0, 16'h0020, 16'h0000, 4'd3);
    tick();
    tick();
    chk("wr_mem_we", {30'd0, bus_if.mem_en, bus_if.mem_we}, 32'd3);
    chk("wr_mem_wdata", 32'(bus_if.mem_wdata), 32'h1234);
    run_until_done(30);

    // Reset asserted in the ISSUE cycle of a requester-0 read
    q0.push_back(mk(1'b0, 16'h0010, 16'h0000, 1'b0));
    tick();
    tick();
    chk("abort_in_issue", 32'(bus_if.mem_en), 32'd1);
    reset = 1'b1;
    q0.delete();
    tick();
    chk("abort_no_ack", {30'd0, bus_if.r1_ack, bus_if.r0_ack}, 32'd0);
    chk("abort_idle", {29'd0, bus_if.busy, bus_if.mem_en, bus_if.grant_id}, 32'd0);
    chk("abort_rdata", {bus_if.r1_rdata, bus_if.r0_rdata}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("abort_still_idle", {29'd0, bus_if.busy, bus_if.r0_ack, bus_if.r1_ack}, 32'd0);

    // Contention from reset: strict alternation 0,1,0,1
    q0.push_back(mk(1'b1, 16'h0030, 16'hAAAA, 1'b0));
    q0.push_back(mk(1'b0, 16'h0040, 16'h0000, 1'b0));
    q1.push_back(mk(1'b1, 16'h0040, 16'h5555, 1'b0));
    q1.push_back(mk(1'b0, 16'h0030, 16'h0000, 1'b0));
    push_exp(1'b0, 1'b1, 16'h0030, 16'hAAAA, 4'd0);
    push_exp(1'b1, 1'b1, 16'h0040, 16'h5555, 4'd3);
    push_exp(1'b0, 1'b0, 16'h0040, 16'h0000, 4'd3);
    push_exp(1'b1, 1'b0, 16'h0030, 16'h0000, 4'd3);
    run_until_done(60);

`ifdef ARB_LOCK_EN
    // Locked requester 1: initial grant plus 8 locked grants, then requester 0
    for (int i = 0; i < 10; i++) begin
      q1.push_back(mk(1'b0, 16'h0010, 16'h0000, 1'b1));
    end
    for (int i = 0; i < 9; i++) begin
      push_exp(1'b1, 1'b0, 16'h0010, 16'h0000, (i == 0) ? 4'd0 : 4'd3);
    end
    push_exp(1'b0, 1'b0, 16'h0020, 16'h0000, 4'd3);
    push_exp(1'b1, 1'b0, 16'h0010, 16'h0000, 4'd3);
    tick();
    q0.push_back(mk(1'b0, 16'h0020, 16'h0000, 1'b0));
    run_until_done(120);
    bus_if.r1_lock = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the multi-cycle processor's single-port unified memory between the CPU memory port (requester 0) and an external program-loader/debug port (requester 1). It serialises transactions through a three-state FSM, grants round-robin on contention, and returns read data with a one-cycle acknowledge pulse. It sits between the processor datapath's memory interface and the memory macro.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LOCK_MAX, 8, max consecutive locked grants to one requester (used only with ARB_LOCK_EN)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- r0_req / r1_req  in  1  transaction request; held with payload until ack
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  ADDR_W  word address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_lock / r1_lock  in  1  request grant retention (ARB_LOCK_EN only)
- r0_ack / r1_ack  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DATA_W  read data; registered, updated only on a read ack to that port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en
- busy  out  1  high in ISSUE and RESP
- grant_id  out  1  registered owner of current/last transaction

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, choose owner, register owner's we/addr/wdata and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive the registered payload to memory with mem_en=1 and mem_we=registered we. Next state is RESP.
- RESP: for a read, capture mem_rdata into the owner's rdata register. Pulse the owner's ack. Next state is IDLE.
- Selection:
  - Exactly one req high: grant that requester.
  - Both high: grant the requester that is not `last`.
  - `last` updates to the owner on every grant.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after ack is treated as a new transaction. A requester that wants a single transfer drops req in the cycle after ack.
- Payload is latched at grant, so requester changes during ISSUE/RESP have no effect.
- mem_en, mem_we are low in IDLE and RESP. mem_addr/mem_wdata hold the last registered payload.

## Timing
- Reset values:
  - state=IDLE, last=1 (requester 0 wins the first tie)
  - all acks 0, mem_en=0, mem_we=0
  - mem_addr=0, mem_wdata=0, r0_rdata=r1_rdata=0
  - grant_id=0, busy=0, lock counter=0
- Latency: req high at IDLE edge N gives mem_en high in cycle N+1 and ack in cycle N+2.
- Throughput: one transaction per 3 cycles. A back-to-back request grants again at N+3.
- Simultaneous requests under continuous contention alternate strictly: 0,1,0,1.
- Reset asserted in ISSUE or RESP:
  - Abort to IDLE at that edge.
  - No ack is issued for the aborted transaction.
  - rdata is cleared; a write issued in ISSUE may already have reached memory.
- A req with no partner never waits more than 0 cycles in IDLE.

## Configuration
- Macro ARB_LOCK_EN.
- Defined:
  - If the owner's lock is high in RESP, and its req is high in the following IDLE, it is re-granted regardless of the other req.
  - A 4-bit lock counter increments per locked re-grant.
  - After LOCK_MAX consecutive locked grants the lock is ignored for one arbitration, and normal round-robin applies.
  - The counter clears on any non-locked grant or on reset.
- Not defined: r0_lock/r1_lock ports are absent, there is no counter, and pure round-robin applies.

## Test plan
- Reset then idle: all outputs 0 and no mem_en for 10 cycles with both req low.
- Single read, r0: memory[0x0010]=0xBEEF, r0_req=1 with addr=0x0010. Expect mem_en at N+1, r0_ack at N+2, r0_rdata=0xBEEF, r1_ack never pulses.
- Write then read, r1: write 0x1234 to 0x0020, then read 0x0020. Expect r1_rdata=0x1234 and two acks 3 cycles apart.
- Contention: both req held high for 4 transactions from reset. Grant order is 0,1,0,1 and grant_id follows the same order.
- Reset mid-transaction: assert reset in the r0 ISSUE cycle. No r0_ack, state IDLE, r0_rdata=0.
- ARB_LOCK_EN, LOCK_MAX=8: r1_lock=1 and both reqs held. Expect 9 r1 grants (initial plus 8 locked), then one r0 grant.
